dot_product_sequencer: RTL and testbench

- Initiator that drives a registered multiply-accumulate datapath (mult stage then accumulate stage) to compute one dot product of a matrix row against a matrix column.
- Reads operand pairs from two synchronous operand RAMs (1-cycle read latency).
- Clears the MAC, streams the operands into it and drains its pipeline.
- Returns the accumulated result over a valid/ready handshake.
- Sits between the matrix operand buffers and the MAC; a higher-level controller issues one `start` per output matrix element.

---
 rtl/dot_product_sequencer.sv | 143 ++++++++++++++
 tb/tb_dot_product_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// Sequences one dot product: clears an external MAC, streams operand pairs read from
// two synchronous RAMs into it, waits out the MAC pipeline and hands back the sum.
module dot_product_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W:0]      len,
  input  logic [ADDR_W-1:0]    a_base,
  input  logic [ADDR_W-1:0]    b_base,
  input  logic [ADDR_W-1:0]    b_stride,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    a_addr,
  output logic [ADDR_W-1:0]    b_addr,
  input  logic [WIDTH-1:0]     a_rdata,
  input  logic [WIDTH-1:0]     b_rdata,
  output logic [WIDTH-1:0]     mac_a,
  output logic [WIDTH-1:0]     mac_b,
  output logic                 mac_clr,
  input  logic [2*WIDTH-1:0]   mac_res,
  output logic                 busy,
  output logic                 res_valid,
  output logic [2*WIDTH-1:0]   res_data,
  input  logic                 res_ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [1:0]          drain_q, drain_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
  logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_en_d1_q;
  logic [WIDTH-1:0]    mac_a_q, mac_b_q;
  logic                res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]  res_data_q, res_data_d;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    drain_d     = drain_q;
    stride_d    = stride_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    rd_en_d     = rd_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d    = len;
          stride_d = b_stride;
          a_addr_d = a_base;
          b_addr_d = b_base;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (rem_q != '0) begin
          rd_en_d = 1'b1;
          state_d = STREAM;
        end else begin
          drain_d = 2'd3;
          state_d = DRAIN;
        end
      end
      STREAM: begin
        // rem_q counts the reads still to issue, including the current one
        a_addr_d = a_addr_q + 1'b1;
        b_addr_d = b_addr_q + stride_q;
        rem_d    = rem_q - 1'b1;
        if (rem_q == 1) begin
          rd_en_d = 1'b0;
          drain_d = 2'd3;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) begin
          res_data_d  = mac_res;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      drain_q     <= '0;
      stride_q    <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      rd_en_q     <= 1'b0;
      rd_en_d1_q  <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      drain_q     <= drain_d;
      stride_q    <= stride_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      rd_en_q     <= rd_en_d;
      rd_en_d1_q  <= rd_en_q;
      // The MAC accumulates every cycle, so feed zeros whenever no read data is arriving
      mac_a_q     <= rd_en_d1_q ? a_rdata : '0;
      mac_b_q     <= rd_en_d1_q ? b_rdata : '0;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_clr   = reset | (state_q == CLEAR);
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: operand RAMs and a two-stage MAC around the DUT,
// results and address sequences compared against a plain-arithmetic dot product.
module tb_dot_product_sequencer;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [ADDR_W:0]     len;
  logic [ADDR_W-1:0]   a_base, b_base, b_stride;
  logic                rd_en;
  logic [ADDR_W-1:0]   a_addr, b_addr;
  logic [WIDTH-1:0]    a_rdata, b_rdata;
  logic [WIDTH-1:0]    mac_a, mac_b;
  logic                mac_clr;
  logic [2*WIDTH-1:0]  mac_res;
  logic                busy;
  logic                res_valid;
  logic [2*WIDTH-1:0]  res_data;
  logic                res_ready;

  logic [WIDTH-1:0]    ram_a [256];
  logic [WIDTH-1:0]    ram_b [256];
  logic [2*WIDTH-1:0]  prod_r, acc_r;

  int n_checks = 0;
  int n_fail   = 0;

  dot_product_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .a_base(a_base), .b_base(b_base), .b_stride(b_stride),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_res(mac_res),
    .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Synchronous operand RAMs, one cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= ram_a[a_addr];
      b_rdata <= ram_b[b_addr];
    end
  end

  // MAC: product register, then accumulator, both cleared by mac_clr
  always @(posedge clk) begin
    if (mac_clr) begin
      prod_r <= '0;
      acc_r  <= '0;
    end else begin
      prod_r <= 16'(mac_a) * 16'(mac_b);
      acc_r  <= acc_r + prod_r;
    end
  end
  assign mac_res = acc_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = WIDTH'($urandom);
      ram_b[i] = WIDTH'($urandom);
    end
  endtask

  task automatic fill_const(input logic [WIDTH-1:0] v);
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = v;
      ram_b[i] = v;
    end
  endtask

  // One complete dot product plus result handshake; entered and left at posedge+1
  task automatic run_dp(input int l, input int ab, input int bb, input int bs, input int hold);
    int          exp_a [$];
    int          exp_b [$];
    int          sum;
    int          cyc;
    int          k;
    logic [15:0] exp_res;
    sum = 0;
    for (int i = 0; i < l; i++) begin
      exp_a.push_back((ab + i) % 256);
      exp_b.push_back((bb + i * bs) % 256);
      sum += int'(ram_a[(ab + i) % 256]) * int'(ram_b[(bb + i * bs) % 256]);
    end
    exp_res = 16'(sum);

    len = 9'(l); a_base = 8'(ab); b_base = 8'(bb); b_stride = 8'(bs);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    k = 0;
    check("clear_busy", busy, 1);
    while (!res_valid && cyc < l + 20) begin
      check("mac_clr", mac_clr, (cyc == 1));
      if (rd_en) begin
        if (k < l) begin
          check("rd_cycle", cyc, k + 2);
          check("a_addr", a_addr, exp_a[k]);
          check("b_addr", b_addr, exp_b[k]);
        end else begin
          check("extra_read", k, l);
        end
        k++;
      end
      tick();
      cyc++;
    end
    check("read_count", k, l);
    check("valid_cycle", cyc, l + 6);
    check("res_data", res_data, exp_res);

    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start = 1'b1;
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp_res);
    end
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    check("hs_valid", res_valid, 0);
    check("hs_busy", busy, 0);
    check("hs_data", res_data, exp_res);
    res_ready = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    $display("dp len=%0d a_base=%0d b_base=%0d stride=%0d result=%0d expected=%0d",
             l, ab, bb, bs, res_data, exp_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; res_ready = 1'b0;
    len = '0; a_base = '0; b_base = '0; b_stride = '0;
    fill_random();
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_a_addr", a_addr, 0);
    check("rst_b_addr", b_addr, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_mac_clr", mac_clr, 1);
    reset = 1'b0;
    tick();
    check("post_rst_clr", mac_clr, 0);

    // Basic
    ram_a[0] = 1; ram_a[1] = 2; ram_a[2] = 3;
    ram_b[0] = 4; ram_b[1] = 5; ram_b[2] = 6;
    run_dp(3, 0, 0, 1, 0);
    // Stride, address wrap, zero length with a held handshake
    run_dp(3, 'h20, 'h10, 4, 2);
    run_dp(3, 'hFE, 'hFF, 1, 0);
    run_dp(0, 5, 7, 3, 5);
    // Overflow and full length
    fill_const(8'd255);
    run_dp(4, 0, 0, 1, 0);
    fill_const(8'd1);
    run_dp(256, 0, 0, 1, 1);

    // Randomized runs
    fill_random();
    for (int r = 0; r < 12; r++) begin
      run_dp($urandom_range(0, 40), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 3));
    end

    // Reset during STREAM, then a fresh run
    len = 9'd30; a_base = 8'd3; b_base = 8'd9; b_stride = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("pre_abort_rd", rd_en, 1);
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_mac_a", mac_a, 0);
    check("abort_mac_b", mac_b, 0);
    check("abort_mac_clr", mac_clr, 1);
    check("abort_valid", res_valid, 0);
    reset = 1'b0;
    tick();
    check("abort_idle", busy, 0);
    run_dp(17, 40, 200, 7, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
